dwt_sample_sequencer: RTL and testbench

DWT_SAMPLE_SEQUENCER -- requirements
Module: dwt_sample_sequencer

---
 rtl/dwt_sample_sequencer.sv | 102 ++++++++++
 tb/tb_dwt_sample_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_sample_sequencer.sv
// dwt_sample_sequencer: pairs ECG samples and issues predict/update operands to the lifting DWT stage
module dwt_sample_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              frame_start,
  output logic [DATA_W-1:0] y2n,
  output logic [DATA_W-1:0] y2n_1,
  output logic [DATA_W-1:0] y2na,
  output logic [1:0]        s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              s5,
  output logic              s6,
  output logic              op_valid,
  output logic [15:0]       pair_idx
);
  typedef enum logic [1:0] {WAIT_EVEN, WAIT_ODD, PREDICT, UPDATE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] even_reg, odd_reg, prev_even;
  logic [DATA_W-1:0] y2n_q, y2n_1_q, y2na_q;
  logic first;
  logic fire;
  assign fire = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_EVEN;
    else     state <= state_n;
  end
  // Operands are live only while issuing; otherwise the last issued values are replayed.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    op_valid = 1'b0;
    s1       = 2'b00;
    {s2, s3, s4, s5, s6} = 5'b0;
    y2n      = y2n_q;
    y2n_1    = y2n_1_q;
    y2na     = y2na_q;
    case (state)
      WAIT_EVEN: begin
        in_ready = 1'b1;
        state_n  = in_valid ? WAIT_ODD : WAIT_EVEN;
      end
      WAIT_ODD: begin
        in_ready = 1'b1;
        state_n  = in_valid ? PREDICT : WAIT_ODD;
      end
      PREDICT: begin
        op_valid = 1'b1;
        y2n      = even_reg;
        y2n_1    = odd_reg;
        y2na     = first ? even_reg : prev_even;
        {s2, s3, s4, s5, s6} = 5'b01001;
        state_n  = UPDATE;
      end
      UPDATE: begin
        op_valid = 1'b1;
        y2n      = even_reg;
        y2n_1    = even_reg;
        y2na     = first ? even_reg : prev_even;
        s1       = first ? 2'b01 : 2'b10;
        {s2, s3, s4, s5, s6} = 5'b10110;
        state_n  = WAIT_EVEN;
      end
      default: state_n = WAIT_EVEN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      even_reg  <= '0;
      odd_reg   <= '0;
      prev_even <= '0;
      y2n_q     <= '0;
      y2n_1_q   <= '0;
      y2na_q    <= '0;
      first     <= 1'b1;
      pair_idx  <= '0;
    end else begin
      if (state == WAIT_EVEN && frame_start) begin
        first    <= 1'b1;
        pair_idx <= '0;
      end
      if (fire && state == WAIT_EVEN) even_reg <= in_data;
      if (fire && state == WAIT_ODD)  odd_reg  <= in_data;
      if (op_valid) begin
        y2n_q   <= y2n;
        y2n_1_q <= y2n_1;
        y2na_q  <= y2na;
      end
      if (state == UPDATE) begin
        prev_even <= even_reg;
        first     <= 1'b0;
        pair_idx  <= pair_idx + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dwt_sample_sequencer.sv
// tb_dwt_sample_sequencer: directed scenarios plus a randomized run against a pair-level reference model
module tb_dwt_sample_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        frame_start = 1'b0;
  logic [31:0] y2n, y2n_1, y2na;
  logic [1:0]  s1;
  logic        s2, s3, s4, s5, s6, op_valid;
  logic [15:0] pair_idx;
  logic [6:0]  sel;
  int checks = 0;
  int errors = 0;

  dwt_sample_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_start(frame_start), .y2n(y2n), .y2n_1(y2n_1), .y2na(y2na),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6),
    .op_valid(op_valid), .pair_idx(pair_idx)
  );

  assign sel = {s1, s2, s3, s4, s5, s6};
  always #5 clk = ~clk;

  // Reference: accepted samples queue up in pairs; a full pair is issued over two cycles.
  logic [31:0] acc[$];
  int          pending = 0;
  logic        m_first = 1'b1;
  logic [15:0] m_idx = '0;
  logic [31:0] m_prev = '0, m_e = '0, m_o = '0;
  logic [31:0] h_y2n = '0, h_y2n_1 = '0, h_y2na = '0;
  logic [31:0] e_y2n, e_y2n_1, e_y2na;
  logic [6:0]  e_sel;

  always @(negedge clk) begin
    if (rst) begin
      acc.delete();
      pending = 0;
      m_first = 1'b1;
      m_idx = '0;
      m_prev = '0;
      {h_y2n, h_y2n_1, h_y2na} = '0;
    end else begin
      e_sel = '0;
      {e_y2n, e_y2n_1, e_y2na} = {h_y2n, h_y2n_1, h_y2na};
      if (pending == 2) begin
        m_e = acc[0];
        m_o = acc[1];
        {e_y2n, e_y2n_1, e_y2na} = {m_e, m_o, m_first ? m_e : m_prev};
        e_sel = 7'b0001001;
      end else if (pending == 1) begin
        {e_y2n, e_y2n_1, e_y2na} = {m_e, m_e, m_first ? m_e : m_prev};
        e_sel = {m_first ? 2'b01 : 2'b10, 5'b10110};
      end
      checks++;
      if (in_ready !== (pending == 0) || op_valid !== (pending != 0)) begin
        errors++;
        $display("FAIL model_handshake ready=%b valid=%b required ready=%b valid=%b", in_ready, op_valid, pending == 0, pending != 0);
      end
      checks++;
      if (sel !== e_sel) begin
        errors++;
        $display("FAIL model_selects got %b required %b", sel, e_sel);
      end
      checks++;
      if ({y2n, y2n_1, y2na} !== {e_y2n, e_y2n_1, e_y2na}) begin
        errors++;
        $display("FAIL model_operands got %h %h %h required %h %h %h", y2n, y2n_1, y2na, e_y2n, e_y2n_1, e_y2na);
      end
      checks++;
      if (pair_idx !== m_idx) begin
        errors++;
        $display("FAIL model_pair_idx got %0d required %0d", pair_idx, m_idx);
      end
      if (pending != 0) {h_y2n, h_y2n_1, h_y2na} = {e_y2n, e_y2n_1, e_y2na};
      if (pending == 2) pending = 1;
      else if (pending == 1) begin
        acc.delete();
        m_prev = m_e;
        m_first = 1'b0;
        m_idx = m_idx + 16'd1;
        pending = 0;
      end else begin
        if (acc.size() == 0 && frame_start) begin
          m_first = 1'b1;
          m_idx = '0;
        end
        if (in_valid) begin
          acc.push_back(in_data);
          if (acc.size() == 2) pending = 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    frame_start = 1'b1;
    in_data = 32'hdeadbeef;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    frame_start = 1'b0;
    checks++;
    if ({in_ready, op_valid, sel} !== {1'b1, 1'b0, 7'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b sel=%b required 1 0 0", in_ready, op_valid, sel);
    end
    checks++;
    if ({y2n, y2n_1, y2na, pair_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h idx=%0d required zeros", y2n, y2n_1, y2na, pair_idx);
    end
  endtask

  task automatic test_vectors();
    in_valid = 1'b1;
    in_data = 32'hbe147ae1;
    tick();
    in_data = 32'hbdf5c28f;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({op_valid, y2n, y2n_1, y2na, s1} !== {1'b1, 32'hbe147ae1, 32'hbdf5c28f, 32'hbe147ae1, 2'b00}) begin
      errors++;
      $display("FAIL vec_predict1 got v=%b %h %h %h s1=%b", op_valid, y2n, y2n_1, y2na, s1);
    end
    tick();
    checks++;
    if ({op_valid, y2n, y2n_1, sel, pair_idx} !== {1'b1, 32'hbe147ae1, 32'hbe147ae1, 7'b0110110, 16'd0}) begin
      errors++;
      $display("FAIL vec_update1 got v=%b %h %h sel=%b idx=%0d required sel=0110110 idx=0", op_valid, y2n, y2n_1, sel, pair_idx);
    end
    tick();
    in_valid = 1'b1;
    in_data = 32'hbe19999a;
    tick();
    in_data = 32'hbe23d70a;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({y2n, y2n_1, y2na} !== {32'hbe19999a, 32'hbe23d70a, 32'hbe147ae1}) begin
      errors++;
      $display("FAIL vec_predict2 got %h %h %h required be19999a be23d70a be147ae1", y2n, y2n_1, y2na);
    end
    tick();
    checks++;
    if ({s1, pair_idx} !== {2'b10, 16'd1}) begin
      errors++;
      $display("FAIL vec_update2 got s1=%b idx=%0d required 10 1", s1, pair_idx);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] e, o;
    e = $urandom;
    o = $urandom;
    in_valid = 1'b1;
    in_data = e;
    tick();
    in_valid = 1'b0;
    in_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_ready, op_valid, sel} !== {1'b1, 1'b0, 7'b0}) begin
        errors++;
        $display("FAIL stall_wait%0d got ready=%b valid=%b sel=%b required 1 0 0", i, in_ready, op_valid, sel);
      end
    end
    in_valid = 1'b1;
    in_data = o;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({op_valid, y2n, y2n_1} !== {1'b1, e, o}) begin
      errors++;
      $display("FAIL stall_resume got v=%b %h %h required 1 %h %h", op_valid, y2n, y2n_1, e, o);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int nr = 0, nv = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      nr += int'(in_ready);
      nv += int'(op_valid);
      checks++;
      if (in_ready !== ((i % 4) < 2)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b required %b", i, in_ready, (i % 4) < 2);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (nr != 20 || nv != 20) begin
      errors++;
      $display("FAIL b2b_counts got ready=%0d valid=%0d required 20 20", nr, nv);
    end
  endtask

  task automatic test_reset_predict();
    logic [31:0] e2;
    in_valid = 1'b1;
    in_data = $urandom;
    tick();
    in_data = $urandom;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, op_valid, sel, y2n, y2n_1, y2na, pair_idx} !== {1'b1, 1'b0, 7'b0, 96'b0, 16'd0}) begin
      errors++;
      $display("FAIL rstp_clear got ready=%b v=%b sel=%b %h %h %h idx=%0d", in_ready, op_valid, sel, y2n, y2n_1, y2na, pair_idx);
    end
    e2 = $urandom;
    in_valid = 1'b1;
    in_data = e2;
    tick();
    in_data = $urandom;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({s1, y2na, pair_idx} !== {2'b01, e2, 16'd0}) begin
      errors++;
      $display("FAIL rstp_first got s1=%b y2na=%h idx=%0d required 01 %h 0", s1, y2na, pair_idx, e2);
    end
    tick();
  endtask

  task automatic test_frame_start();
    logic [31:0] b;
    in_valid = 1'b1;
    in_data = $urandom;
    tick();
    in_data = $urandom;
    tick();
    in_valid = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (pair_idx !== 16'd2) begin
      errors++;
      $display("FAIL frame_ignored got idx=%0d required 2", pair_idx);
    end
    b = $urandom;
    frame_start = 1'b1;
    in_valid = 1'b1;
    in_data = b;
    tick();
    frame_start = 1'b0;
    in_data = $urandom;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({s1, y2na, pair_idx} !== {2'b01, b, 16'd0}) begin
      errors++;
      $display("FAIL frame_restart got s1=%b y2na=%h idx=%0d required 01 %h 0", s1, y2na, pair_idx, b);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      frame_start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    {rst, in_valid, frame_start} = 3'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_predict();
    test_frame_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
